// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
//   fwd_sel_t   : execute-stage ALU operand source select
//   hz_state_t  : hazard sequencing FSM state
//   NOP_INSTR   : bubble instruction loaded by a flushed pipeline register
//   fwd_select  : forwarding priority rule (Memory beats Writeback)
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_t;

  typedef enum logic [1:0] {
    RUN   = 2'b00,
    IWAIT = 2'b01,
    IDROP = 2'b10,
    DWAIT = 2'b11
  } hz_state_t;

  localparam logic [31:0] NOP_INSTR = 32'h00000013;

  // x0 is never a forwarding source: writes to it are discarded.
  function automatic fwd_sel_t fwd_select(input logic [4:0] rs,
                                          input logic [4:0] rd_m,
                                          input logic       we_m,
                                          input logic [4:0] rd_w,
                                          input logic       we_w);
    fwd_sel_t sel;
    sel = FWD_RF;
    if (we_m && (rd_m != 5'd0) && (rd_m == rs)) begin
      sel = FWD_M;
    end else if (we_w && (rd_w != 5'd0) && (rd_w == rs)) begin
      sel = FWD_W;
    end
    return sel;
  endfunction

endpackage

// File: rtl/hazard_ctrl_perf_ctr.sv
// Saturating performance counter.
//   clk, rst : clock, synchronous active-high reset (counter to zero)
//   clr      : synchronous clear, wins over inc
//   inc      : add one this cycle unless already all-ones
//   cnt      : current count
module hazard_perf_ctr #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 inc,
  output logic [CNT_WIDTH-1:0] cnt
);

  localparam logic [CNT_WIDTH-1:0] ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic [CNT_WIDTH-1:0] cnt_q;
  logic [CNT_WIDTH-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for the five-stage RV32I core.
//   Inputs : decode/execute/memory/writeback register specifiers and write
//            enables, load-in-Execute flag, branch mispredict, instruction
//            and data memory handshakes, perf counter clear.
//   Outputs: per-stage stall and flush controls, execute forwarding selects,
//            three saturating performance counters, and dbg_state (current
//            FSM state) for observation.
//
// Handshake: imem_ready=1 means the instruction word presented this cycle is
// valid; a data access is pending (dmem_reqM=1) until the cycle dmem_ready=1,
// and each cycle with dmem_reqM=1, dmem_ready=0 freezes the whole pipeline.
//
// The FSM keeps the instruction-side progress (RUN/IWAIT/IDROP) in iside_q
// while a data miss parks it in DWAIT, so the I-side sequence resumes after
// the data access completes.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [4:0]           Rs1D,
  input  logic [4:0]           Rs2D,
  input  logic [4:0]           Rs1E,
  input  logic [4:0]           Rs2E,
  input  logic [4:0]           RdE,
  input  logic                 ResultSrcE0,
  input  logic [4:0]           RdM,
  input  logic                 RegWriteM,
  input  logic [4:0]           RdW,
  input  logic                 RegWriteW,
  input  logic                 mispredictE,
  input  logic                 imem_ready,
  input  logic                 dmem_reqM,
  input  logic                 dmem_ready,
  input  logic                 perf_clr,
  output logic                 StallF,
  output logic                 StallD,
  output logic                 StallE,
  output logic                 StallM,
  output logic                 FlushD,
  output logic                 FlushE,
  output logic                 FlushW,
  output logic [1:0]           ForwardAE,
  output logic [1:0]           ForwardBE,
  output logic [CNT_WIDTH-1:0] stall_cnt,
  output logic [CNT_WIDTH-1:0] flush_cnt,
  output logic [CNT_WIDTH-1:0] lwstall_cnt,
  output hz_state_t            dbg_state
);

  hz_state_t state_q, state_d;
  hz_state_t iside_q, iside_d;
  hz_state_t i_cur, i_next;

  logic lw_stall;
  logic dmiss;
  logic lw_take;

  assign lw_stall = ResultSrcE0 && (RdE != 5'd0) && ((RdE == Rs1D) || (RdE == Rs2D));
  assign dmiss    = dmem_reqM && !dmem_ready;

  // Instruction-side view of the FSM, valid even while parked in DWAIT.
  assign i_cur = (state_q == DWAIT) ? iside_q : state_q;

  // ---------------- state register ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      iside_q <= RUN;
    end else begin
      state_q <= state_d;
      iside_q <= iside_d;
    end
  end

  // ---------------- next-state logic ----------------
  always_comb begin
    // I-side successor when the pipeline is free to move.
    i_next = i_cur;
    if (mispredictE) begin
      // Outstanding fetch is wrong-path if it has not returned yet.
      i_next = imem_ready ? RUN : IDROP;
    end else if (imem_ready) begin
      // IWAIT: word delivered; IDROP: word squashed or held out of Decode.
      i_next = RUN;
    end else if (lw_stall) begin
      i_next = i_cur;
    end else if (i_cur == IDROP) begin
      i_next = IDROP;
    end else begin
      i_next = IWAIT;
    end

    state_d = i_next;
    iside_d = i_next;
    if (dmiss) begin
      state_d = DWAIT;
      // A fetch returning during the freeze is recorded as complete; Decode
      // and PC are held so the word never enters the pipeline.
      iside_d = imem_ready ? RUN : i_cur;
    end
  end

  // ---------------- output logic ----------------
  always_comb begin
    StallF  = 1'b0;
    StallD  = 1'b0;
    StallE  = 1'b0;
    StallM  = 1'b0;
    FlushD  = 1'b0;
    FlushE  = 1'b0;
    FlushW  = 1'b0;
    lw_take = 1'b0;
    if (rst) begin
      FlushD = 1'b1;
      FlushE = 1'b1;
      FlushW = 1'b1;
    end else if (dmiss) begin
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      StallM = 1'b1;
      FlushW = 1'b1;
    end else if (mispredictE) begin
      FlushD = 1'b1;
      FlushE = 1'b1;
    end else if (lw_stall) begin
      StallF  = 1'b1;
      StallD  = 1'b1;
      FlushE  = 1'b1;
      lw_take = 1'b1;
    end else if (!imem_ready || (i_cur == IDROP)) begin
      // In IDROP the PC already holds the target, so it stays held on the
      // cycle the wrong-path word returns and that word becomes a bubble.
      StallF = 1'b1;
      FlushD = 1'b1;
    end
  end

  always_comb begin
    ForwardAE = FWD_RF;
    ForwardBE = FWD_RF;
    if (!rst) begin
      ForwardAE = fwd_select(Rs1E, RdM, RegWriteM, RdW, RegWriteW);
      ForwardBE = fwd_select(Rs2E, RdM, RegWriteM, RdW, RegWriteW);
    end
  end

  assign dbg_state = state_q;

  // ---------------- performance counters ----------------
  hazard_perf_ctr #(.CNT_WIDTH(CNT_WIDTH)) u_stall_ctr (
    .clk (clk),
    .rst (rst),
    .clr (perf_clr),
    .inc (StallF),
    .cnt (stall_cnt)
  );

  hazard_perf_ctr #(.CNT_WIDTH(CNT_WIDTH)) u_flush_ctr (
    .clk (clk),
    .rst (rst),
    .clr (perf_clr),
    .inc (FlushE),
    .cnt (flush_cnt)
  );

  hazard_perf_ctr #(.CNT_WIDTH(CNT_WIDTH)) u_lwstall_ctr (
    .clk (clk),
    .rst (rst),
    .clr (perf_clr),
    .inc (lw_take),
    .cnt (lwstall_cnt)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;
  import hazard_pkg::*;

  localparam int W = 7;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic       ResultSrcE0, RegWriteM, RegWriteW, mispredictE;
  logic       imem_ready, dmem_reqM, dmem_ready, perf_clr;

  logic        StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW;
  logic [1:0]  ForwardAE, ForwardBE;
  logic [31:0] stall_cnt, flush_cnt, lwstall_cnt;
  hz_state_t   dbg_state;

  logic        s4_StallF, s4_StallD, s4_StallE, s4_StallM;
  logic        s4_FlushD, s4_FlushE, s4_FlushW;
  logic [1:0]  s4_ForwardAE, s4_ForwardBE;
  logic [3:0]  s4_stall_cnt, s4_flush_cnt, s4_lwstall_cnt;
  hz_state_t   s4_dbg_state;

  // {StallF,StallD,StallE,StallM,FlushD,FlushE,FlushW}
  logic [W-1:0] ctrl;
  assign ctrl = {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW};

  hazard_ctrl #(.CNT_WIDTH(32)) u_dut (
    .clk(clk), .rst(rst),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
    .ResultSrcE0(ResultSrcE0), .RdM(RdM), .RegWriteM(RegWriteM),
    .RdW(RdW), .RegWriteW(RegWriteW), .mispredictE(mispredictE),
    .imem_ready(imem_ready), .dmem_reqM(dmem_reqM), .dmem_ready(dmem_ready),
    .perf_clr(perf_clr),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .lwstall_cnt(lwstall_cnt),
    .dbg_state(dbg_state)
  );

  hazard_ctrl #(.CNT_WIDTH(4)) u_dut4 (
    .clk(clk), .rst(rst),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
    .ResultSrcE0(ResultSrcE0), .RdM(RdM), .RegWriteM(RegWriteM),
    .RdW(RdW), .RegWriteW(RegWriteW), .mispredictE(mispredictE),
    .imem_ready(imem_ready), .dmem_reqM(dmem_reqM), .dmem_ready(dmem_ready),
    .perf_clr(perf_clr),
    .StallF(s4_StallF), .StallD(s4_StallD), .StallE(s4_StallE), .StallM(s4_StallM),
    .FlushD(s4_FlushD), .FlushE(s4_FlushE), .FlushW(s4_FlushW),
    .ForwardAE(s4_ForwardAE), .ForwardBE(s4_ForwardBE),
    .stall_cnt(s4_stall_cnt), .flush_cnt(s4_flush_cnt), .lwstall_cnt(s4_lwstall_cnt),
    .dbg_state(s4_dbg_state)
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_idle();
    Rs1D = 5'd0; Rs2D = 5'd0; Rs1E = 5'd0; Rs2E = 5'd0;
    RdE = 5'd0; RdM = 5'd0; RdW = 5'd0;
    ResultSrcE0 = 1'b0; RegWriteM = 1'b0; RegWriteW = 1'b0;
    mispredictE = 1'b0; imem_ready = 1'b1;
    dmem_reqM = 1'b0; dmem_ready = 1'b1; perf_clr = 1'b0;
  endtask

  // Advance one clock; inputs are then changed 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    drive_idle();
    // Inputs that would otherwise forward, stall and miss: all masked by reset.
    RegWriteM = 1'b1; RdM = 5'd5; Rs1E = 5'd5;
    RegWriteW = 1'b1; RdW = 5'd5; Rs2E = 5'd5;
    imem_ready = 1'b0; dmem_reqM = 1'b1; dmem_ready = 1'b0;
    #1;
    check_val("rst_ctrl", 32'(ctrl), 32'(7'b0000111));
    check_val("rst_fwda", 32'(ForwardAE), 32'd0);
    check_val("rst_fwdb", 32'(ForwardBE), 32'd0);
    tick(); tick();
    check_val("rst_state", 32'(dbg_state), 32'(RUN));
    check_val("rst_stall_cnt", stall_cnt, 32'd0);
    check_val("rst_flush_cnt", flush_cnt, 32'd0);
    check_val("rst_lw_cnt", lwstall_cnt, 32'd0);
    check_val("rst_s4_stall_cnt", 32'(s4_stall_cnt), 32'd0);

    rst = 1'b0;
    drive_idle();
    #1;
    check_val("idle_ctrl", 32'(ctrl), 32'd0);

    // Forwarding (combinational, no clock edges).
    RegWriteM = 1'b1; RegWriteW = 1'b1; RdM = 5'd5; RdW = 5'd5; Rs1E = 5'd5; Rs2E = 5'd5;
    #1;
    check_val("fwd_a_mem_prio", 32'(ForwardAE), 32'd2);
    check_val("fwd_b_mem_prio", 32'(ForwardBE), 32'd2);
    RdM = 5'd0;
    #1;
    check_val("fwd_a_wb", 32'(ForwardAE), 32'd1);
    check_val("fwd_b_wb", 32'(ForwardBE), 32'd1);
    RegWriteW = 1'b0;
    #1;
    check_val("fwd_a_none", 32'(ForwardAE), 32'd0);
    RdM = 5'd0; RegWriteM = 1'b1; RdW = 5'd0; RegWriteW = 1'b1; Rs1E = 5'd0;
    #1;
    check_val("fwd_a_x0", 32'(ForwardAE), 32'd0);
    Rs1E = 5'd5; Rs2E = 5'd7; RdW = 5'd7; RegWriteW = 1'b1; RdM = 5'd7; RegWriteM = 1'b0;
    #1;
    check_val("fwd_b_wb2", 32'(ForwardBE), 32'd1);
    check_val("fwd_a_nomatch", 32'(ForwardAE), 32'd0);
    RegWriteM = 1'b1;
    #1;
    check_val("fwd_b_mem2", 32'(ForwardBE), 32'd2);
    check_val("fwd_ctrl", 32'(ctrl), 32'd0);

    // Load-use: combinational corner cases first, no clock edge.
    drive_idle();
    ResultSrcE0 = 1'b1; RdE = 5'd0; Rs1D = 5'd0;
    #1;
    check_val("lu_x0", 32'(ctrl), 32'd0);
    RdE = 5'd9; Rs1D = 5'd3; Rs2D = 5'd9;
    #1;
    check_val("lu_rs2", 32'(ctrl), 32'(7'b1100010));
    ResultSrcE0 = 1'b0;
    #1;
    check_val("lu_not_load", 32'(ctrl), 32'd0);

    // lw x5 in Execute, add x6,x5,x1 in Decode.
    drive_idle();
    ResultSrcE0 = 1'b1; RdE = 5'd5; Rs1D = 5'd5; Rs2D = 5'd1;
    #1;
    check_val("lu_stall", 32'(ctrl), 32'(7'b1100010));
    tick();
    ResultSrcE0 = 1'b0; RdE = 5'd0; RdM = 5'd5; RegWriteM = 1'b1;
    #1;
    check_val("lu_release", 32'(ctrl), 32'd0);
    tick();
    check_val("lu_lw_cnt", lwstall_cnt, 32'd1);
    check_val("lu_stall_cnt", stall_cnt, 32'd1);
    check_val("lu_flush_cnt", flush_cnt, 32'd1);

    // Clear wins over an increment in the same cycle.
    drive_idle();
    perf_clr = 1'b1; imem_ready = 1'b0;
    #1;
    check_val("clr_ctrl", 32'(ctrl), 32'(7'b1000100));
    tick();
    check_val("clr_stall_cnt", stall_cnt, 32'd0);
    check_val("clr_lw_cnt", lwstall_cnt, 32'd0);
    check_val("clr_state", 32'(dbg_state), 32'(IWAIT));
    perf_clr = 1'b0; imem_ready = 1'b1;
    #1;
    check_val("iwait_exit_ctrl", 32'(ctrl), 32'd0);
    tick();
    check_val("iwait_exit_state", 32'(dbg_state), 32'(RUN));

    // I-miss for 3 cycles.
    for (int i = 0; i < 3; i++) exp_q.push_back(7'b1000100);
    exp_q.push_back(7'b0000000);
    for (int i = 0; i < 3; i++) begin
      imem_ready = 1'b0;
      #1;
      check_val("imiss_ctrl", 32'(ctrl), 32'(exp_q.pop_front()));
      tick();
      check_val("imiss_state", 32'(dbg_state), 32'(IWAIT));
    end
    imem_ready = 1'b1;
    #1;
    check_val("imiss_done_ctrl", 32'(ctrl), 32'(exp_q.pop_front()));
    tick();
    check_val("imiss_state_run", 32'(dbg_state), 32'(RUN));
    check_val("imiss_stall_cnt", stall_cnt, 32'd3);
    check_val("imiss_flush_cnt", flush_cnt, 32'd0);

    // Mispredict during I-miss.
    drive_idle();
    mispredictE = 1'b1; imem_ready = 1'b0;
    #1;
    check_val("mp_ctrl", 32'(ctrl), 32'(7'b0000110));
    tick();
    check_val("mp_state", 32'(dbg_state), 32'(IDROP));
    mispredictE = 1'b0; imem_ready = 1'b0;
    #1;
    check_val("idrop_wait_stallf", 32'(StallF), 32'd1);
    check_val("idrop_wait_flushe", 32'(FlushE), 32'd0);
    tick();
    check_val("idrop_state", 32'(dbg_state), 32'(IDROP));
    imem_ready = 1'b1;
    #1;
    check_val("idrop_squash_flushd", 32'(FlushD), 32'd1);
    check_val("idrop_squash_flushe", 32'(FlushE), 32'd0);
    tick();
    check_val("idrop_exit_state", 32'(dbg_state), 32'(RUN));
    #1;
    check_val("idrop_after_ctrl", 32'(ctrl), 32'd0);

    // D-miss with mispredict held for 4 cycles.
    perf_clr = 1'b1;
    tick();
    perf_clr = 1'b0;
    for (int i = 0; i < 4; i++) begin
      dmem_reqM = 1'b1; dmem_ready = 1'b0; mispredictE = 1'b1;
      #1;
      check_val("dmiss_ctrl", 32'(ctrl), 32'(7'b1111001));
      tick();
      check_val("dmiss_state", 32'(dbg_state), 32'(DWAIT));
    end
    dmem_ready = 1'b1;
    #1;
    check_val("dmiss_release_ctrl", 32'(ctrl), 32'(7'b0000110));
    tick();
    check_val("dmiss_release_state", 32'(dbg_state), 32'(RUN));
    check_val("dmiss_stall_cnt", stall_cnt, 32'd4);
    check_val("dmiss_flush_cnt", flush_cnt, 32'd1);
    check_val("dmiss_lw_cnt", lwstall_cnt, 32'd0);

    // D-miss while in IDROP: squash still pending after release.
    drive_idle();
    mispredictE = 1'b1; imem_ready = 1'b0;
    tick();
    mispredictE = 1'b0; dmem_reqM = 1'b1; dmem_ready = 1'b0;
    #1;
    check_val("idrop_dmiss_ctrl", 32'(ctrl), 32'(7'b1111001));
    tick();
    tick();
    check_val("idrop_dmiss_state", 32'(dbg_state), 32'(DWAIT));
    dmem_ready = 1'b1; imem_ready = 1'b1;
    #1;
    check_val("idrop_resume_ctrl", 32'(ctrl), 32'(7'b1000100));
    tick();
    check_val("idrop_resume_state", 32'(dbg_state), 32'(RUN));

    // Reset during DWAIT (with an IDROP underneath).
    drive_idle();
    mispredictE = 1'b1; imem_ready = 1'b0;
    tick();
    mispredictE = 1'b0; dmem_reqM = 1'b1; dmem_ready = 1'b0;
    tick();
    check_val("pre_rst_state", 32'(dbg_state), 32'(DWAIT));
    rst = 1'b1;
    #1;
    check_val("rst_dwait_ctrl", 32'(ctrl), 32'(7'b0000111));
    tick();
    check_val("rst_dwait_state", 32'(dbg_state), 32'(RUN));
    check_val("rst_dwait_stall_cnt", stall_cnt, 32'd0);
    check_val("rst_dwait_flush_cnt", flush_cnt, 32'd0);
    rst = 1'b0;
    drive_idle();
    #1;
    check_val("no_pending_squash", 32'(ctrl), 32'd0);
    tick();

    // Saturation: 20 stall cycles.
    for (int i = 0; i < 20; i++) begin
      imem_ready = 1'b0;
      tick();
    end
    imem_ready = 1'b1;
    #1;
    check_val("sat_stall_cnt_32", stall_cnt, 32'd20);
    check_val("sat_stall_cnt_4", 32'(s4_stall_cnt), 32'd15);
    tick();
    check_val("sat_hold_4", 32'(s4_stall_cnt), 32'd15);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the five-stage RV32I core. It drives the stall and flush controls of every pipeline register, including `StallD`/`FlushD` of the fetch/decode register, and generates the execute-stage forwarding selects. A small FSM sequences multi-cycle instruction-memory and data-memory waits and squashes wrong-path fetches that return after a branch mispredict. Saturating performance counters record stall and flush activity.

## Interface
- `CNT_WIDTH`, 32, width of each performance counter
- `clk`  in  1  core clock
- `rst`  in  1  synchronous, active-high reset
- `Rs1D`, `Rs2D`  in  5 each  source registers in Decode
- `Rs1E`, `Rs2E`, `RdE`  in  5 each  source and destination registers in Execute
- `ResultSrcE0`  in  1  instruction in Execute is a load
- `RdM`, `RegWriteM`  in  5, 1  Memory-stage destination and write enable
- `RdW`, `RegWriteW`  in  5, 1  Writeback-stage destination and write enable
- `mispredictE`  in  1  branch/jump resolved in Execute disagrees with `branch_predictE`
- `imem_ready`  in  1  instruction memory returns valid data this cycle
- `dmem_reqM`, `dmem_ready`  in  1, 1  data access in Memory; data memory done
- `perf_clr`  in  1  synchronous clear of all counters
- `StallF`, `StallD`, `StallE`, `StallM`  out  1 each  hold the pipeline register
- `FlushD`, `FlushE`, `FlushW`  out  1 each  load a bubble (NOP `32'h00000013`, control signals zero)
- `ForwardAE`, `ForwardBE`  out  2 each  ALU operand source
- `stall_cnt`, `flush_cnt`, `lwstall_cnt`  out  `CNT_WIDTH` each  performance counters

## Operation
- Forwarding is combinational:
  - `ForwardAE = 2'b10` if `RegWriteM` and `RdM != 0` and `RdM == Rs1E`.
  - Otherwise `2'b01` if `RegWriteW` and `RdW != 0` and `RdW == Rs1E`.
  - Otherwise `2'b00`.
  - `ForwardBE` uses the same rule with `Rs2E`. Memory has priority over Writeback.
- `lwStall = ResultSrcE0 & (RdE != 0) & (RdE == Rs1D | RdE == Rs2D)`.
- `dmiss = dmem_reqM & ~dmem_ready`.
- FSM states: `RUN`, `IWAIT`, `IDROP`, `DWAIT`.
- Control priority per cycle, highest first:
  - **dmiss:** `StallF`, `StallD`, `StallE`, `StallM` = 1 and `FlushW` = 1. All other flushes are 0. Next state is `DWAIT`; the FSM stays there until `dmem_ready`, then returns to the prior I-side state. The I-side state is held in a separate flag.
  - **mispredictE:** `FlushD` = 1 and `FlushE` = 1. The PC is allowed to load the target (`StallF` = 0). If `~imem_ready`, the next state is `IDROP`.
  - **lwStall:** `StallF` = 1, `StallD` = 1, `FlushE` = 1. This takes one cycle and the condition clears once the load reaches Memory.
  - **~imem_ready:** `StallF` = 1 and `FlushD` = 1, which inserts a bubble into Decode while later stages advance. Next state is `IWAIT`.
- `IWAIT`: exit to `RUN` on the first `imem_ready` cycle. That instruction is passed into Decode.
- `IDROP`: `StallF` = 1 until `imem_ready`. On that cycle the returned wrong-path word is squashed (`FlushD` = 1), then the FSM goes to `RUN`.
  - A second mispredict while in `IDROP` keeps the FSM in `IDROP`.
- A mispredict while in `DWAIT` is not acted on. Execute is frozen, so `mispredictE` stays asserted and is serviced on the first cycle after release.
- Counters saturate at all-ones and never wrap. Each counter adds at most 1 per cycle:
  - `stall_cnt` counts cycles with `StallF` = 1.
  - `flush_cnt` counts cycles with `FlushE` = 1.
  - `lwstall_cnt` counts `lwStall` cycles that actually took effect.
  - `perf_clr` wins over an increment in the same cycle.

## Timing
- Stall, flush and forward outputs are combinational from the current inputs and the FSM state, so they act on the next `clk` edge.
- State and counters update on `posedge clk`.
- While `rst` = 1:
  - `FlushD`, `FlushE`, `FlushW` = 1.
  - All stalls are 0 and the forward selects are `2'b00`.
  - Next state is `RUN` and the counters are set to 0.
- Reset asserted during `IDROP` or `DWAIT` abandons the sequence immediately. There is no pending squash after reset.
- Memory latency is unbounded; the FSM waits indefinitely.
- If `imem_ready` and `dmiss` occur in the same cycle while in `IWAIT`, the fetch completion is recorded in the I-side flag. The Decode load is held by `StallD`.

## Structure
- Shared `hazard_pkg`:
  - `fwd_sel_t` enum: `FWD_RF = 2'b00`, `FWD_W = 2'b01`, `FWD_M = 2'b10`.
  - `hz_state_t` enum covering the four FSM states.
  - Constant `NOP_INSTR = 32'h00000013`.
- One sub-module, `hazard_perf_ctr`: a saturating counter with increment and clear, parameterised by `CNT_WIDTH`. It is instantiated three times.

## Test plan
- **Forwarding:** `RdM = RdW = Rs1E = 5`, both write enables high -> `ForwardAE = 10`. With `RdM = 0` -> `ForwardAE = 01`.
- **Load-use:** `lw x5` in Execute, `add x6, x5, x1` in Decode -> exactly one cycle of `StallF = StallD = FlushE = 1`, and `lwstall_cnt = 1`.
- **I-miss:** `imem_ready` low for 3 cycles -> `StallF = FlushD = 1` for 3 cycles, Execute advances, `stall_cnt = 3`.
- **Mispredict during I-miss:** `mispredictE` with `imem_ready = 0` -> `FlushD = FlushE = 1`, then `IDROP`. When `imem_ready` rises 2 cycles later, `FlushD = 1` on that cycle, then `RUN`.
- **D-miss with concurrent mispredict:** `dmiss` for 4 cycles with `mispredictE` held -> all stalls plus `FlushW` for 4 cycles and `FlushE = 0` throughout. `FlushE = 1` on cycle 5.
- **Reset and saturation:** reset during `DWAIT` -> state `RUN`, counters 0. With `CNT_WIDTH = 4` and 20 stall cycles -> `stall_cnt = 15`.
